// File: rtl/udp_rec_pkg.sv
// Shared constants, record layout and FSM states for the UDP flow-record path.
// Shared by udp_pkt_rec_fifo (top) and rec_sync_fifo.
package udp_rec_pkg;
  localparam int REC_SRC_W = 32;
  localparam int REC_DST_W = 32;
  localparam int REC_XOR_W = 32;
  localparam int REC_LEN_W = 16;
  localparam int DROP_W    = 16;

  typedef struct packed {
    logic [REC_SRC_W-1:0] src;
    logic [REC_DST_W-1:0] dst;
    logic [REC_LEN_W-1:0] len;
    logic [REC_XOR_W-1:0] dig;
  } rec_t;

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_e;
endpackage

// File: rtl/rec_sync_fifo.sv
// Generic show-ahead synchronous FIFO; head is valid the cycle after a push.
// Data output reads as zero while empty.
module rec_sync_fifo
  import udp_rec_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] dout_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          pop, wr_en;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign pop     = valid_o && ready_i;
  // When full, a same-cycle pop frees the slot being written.
  assign wr_en   = push_i && (!full_o || pop);
  assign dout_o  = valid_o ? mem_q[rd_q] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/udp_pkt_rec_fifo.sv
// Per-packet flow-record builder and buffer for the UDP receive path.
// Define UDP_REC_XOR_EN to add the payload XOR digest to each record.
module udp_pkt_rec_fifo
  import udp_rec_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int LEN_W = REC_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rec_en,
  input  logic [31:0]          rec_data,
  input  logic                 rec_pkt_done,
  input  logic [31:0]          src,
  input  logic [31:0]          dst,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_src,
  output logic [31:0]          out_dst,
  output logic [LEN_W-1:0]     out_len,
  output logic [31:0]          out_xor,
  output logic [DROP_W-1:0]    drop_cnt,
  output logic                 ovf
);
`ifdef UDP_REC_XOR_EN
  localparam int XW = REC_XOR_W;
`else
  localparam int XW = 0;
`endif
  localparam int DW = REC_SRC_W + REC_DST_W + LEN_W + XW;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_fin, cnt_inc;
  logic [DW-1:0]    din, dout;
  logic             full, drop;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign len_fin = rec_en ? cnt_inc : cnt_q;

`ifdef UDP_REC_XOR_EN
  logic [31:0] xor_q, xor_d, xor_fin;
  assign xor_fin = rec_en ? (xor_q ^ rec_data) : xor_q;
  assign din     = {src, dst, len_fin, xor_fin};
  assign out_xor = dout[XW-1:0];
`else
  logic unused_data;
  assign unused_data = ^rec_data;
  assign din         = {src, dst, len_fin};
  assign out_xor     = '0;
`endif

  assign out_src = dout[DW-1 -: REC_SRC_W];
  assign out_dst = dout[DW-REC_SRC_W-1 -: REC_DST_W];
  assign out_len = dout[XW +: LEN_W];

  // Only a full FIFO without a same-cycle pop loses the record.
  assign drop = rec_pkt_done && full && !(out_valid && out_ready);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef UDP_REC_XOR_EN
    xor_d   = xor_q;
`endif
    if (rec_pkt_done) begin
      state_d = IDLE;
      cnt_d   = '0;
`ifdef UDP_REC_XOR_EN
      xor_d   = '0;
`endif
    end else if (rec_en) begin
      state_d = IN_PKT;
      cnt_d   = (state_q == IDLE) ? LEN_W'(1) : cnt_inc;
`ifdef UDP_REC_XOR_EN
      xor_d   = (state_q == IDLE) ? rec_data : xor_fin;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
`ifdef UDP_REC_XOR_EN
      xor_q    <= '0;
`endif
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
`ifdef UDP_REC_XOR_EN
      xor_q    <= xor_d;
`endif
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  rec_sync_fifo #(
    .W     (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rec_pkt_done),
    .din_i   (din),
    .full_o  (full),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .dout_o  (dout)
  );
endmodule

// File: doc/udp_pkt_rec_fifo.md
Name: udp_pkt_rec_fifo

Overview:
- Downstream consumer of the UDP receive stage.
- Takes per-packet outputs `rec_en`, `rec_data`, `rec_pkt_done`, `src` and `dst`, and counts payload words per packet.
- At packet end, builds one fixed-format flow record and buffers it in a small synchronous FIFO.
- Presents records on a valid/ready interface to the PCIe upload path; overflow is counted, never stalls the receiver.

Parameters:
- DEPTH, 16, FIFO depth in records; power of two, 2..256.
- AW, 4, FIFO address width; must equal log2(DEPTH).
- LEN_W, 16, word-count width; counter saturates at all-ones.

Ports:
- clk  in  1  single clock, same domain as the receive-stage outputs.
- rst_n  in  1  synchronous, active-low reset.
- rec_en  in  1  payload word strobe.
- rec_data  in  32  payload word, valid when rec_en=1.
- rec_pkt_done  in  1  single-cycle end-of-packet pulse.
- src  in  32  source IP; stable when rec_pkt_done=1.
- dst  in  32  destination IP; stable when rec_pkt_done=1.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts head record.
- out_src  out  32  record source IP.
- out_dst  out  32  record destination IP.
- out_len  out  LEN_W  payload words in the packet.
- out_xor  out  32  payload XOR digest; 0 when the feature is compiled out.
- drop_cnt  out  16  records dropped on full; saturating.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all outputs 0; FIFO empty.
  - state=IDLE; word counter and xor accumulator cleared.
  - reset mid-packet discards the partial packet and emits no record.
- States and transitions:
  - IDLE --rec_en--> IN_PKT with cnt=1.
  - IN_PKT --rec_en--> cnt+1, saturating at 2^LEN_W-1.
  - IN_PKT --rec_pkt_done--> IDLE.
  - IDLE --rec_pkt_done, no rec_en--> record with len 0 and xor 0.
- Same-cycle rec_en and rec_pkt_done:
  - that word is included in len and xor.
  - counter and accumulator restart at 0 next cycle.
- Push:
  - a record {src, dst, final len, final xor} is written on the rec_pkt_done cycle.
  - src and dst are sampled on that edge.
  - out_valid rises 1 cycle after rec_pkt_done when the FIFO was empty (registered show-ahead head).
- Pop:
  - a transfer occurs when out_valid and out_ready are both 1.
  - the next head appears on the following cycle with no bubble.
  - out_* hold stable while out_valid=1 and out_ready=0.
- Full FIFO:
  - push with no pop in the same cycle drops the record; drop_cnt+1 (saturating at 0xFFFF) and ovf<=1.
  - push and pop in the same cycle are both accepted; occupancy is unchanged.
- Empty FIFO:
  - out_valid=0; out_ready is ignored.
  - a push into an empty FIFO with out_ready=1 does not pass through in the same cycle.
- Pointers wrap modulo DEPTH; occupancy counter is AW+1 bits wide.
- ovf clears only on reset.

Optional Feature:
- Macro: UDP_REC_XOR_EN.
- Defined: a 32-bit accumulator XORs every accepted rec_data word of the packet. The final value is stored in the record and driven on out_xor.
- Undefined:
  - no accumulator and no xor storage in the FIFO.
  - out_xor is tied to 0.
  - all other timing is identical.

Decomposition:
- Package udp_rec_pkg holds:
  - REC_SRC_W=32, REC_DST_W=32, REC_XOR_W=32 and DROP_W=16 constants.
  - the record struct typedef {src, dst, len, xor}.
  - the state enum {IDLE, IN_PKT}.
- One natural sub-module: rec_sync_fifo, a generic show-ahead synchronous FIFO parameterised by width and depth.
- The top level holds the packet FSM, counters and overflow logic.

Test Plan:
- Packet of 5 rec_en words 0x1..0x5, src=0xC0A80001, dst=0xC0A80002, then rec_pkt_done -> one record with len=5, xor=0x1 (macro defined), out_valid rises 1 cycle after done.
- rec_pkt_done asserted together with the 3rd rec_en -> len=3; the next packet starts from len 0.
- 17 single-word packets with out_ready=0 and DEPTH=16 -> 16 records stored; drop_cnt=1, ovf=1. Then out_ready=1 drains the 16 in order, one per cycle.
- FIFO full with push and out_ready=1 on the same cycle -> no drop; occupancy stays 16.
- rst_n=0 for one cycle mid-packet, then a 2-word packet -> only one record emitted, with len=2; drop_cnt=0.
- out_ready toggling 1/0 every cycle over 4 queued records -> each record is presented stable until accepted, with no duplicates or losses.
